// File: rtl/pixel_unpack_pkg.sv
// Shared types for the pixel unpacker: payload mode, FSM states and the
// RGB565 -> RGB444 truncation.
package pixel_unpack_pkg;

  typedef enum logic {
    MODE_RGB565 = 1'b0,
    MODE_PACK12 = 1'b1
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PH0,
    ST_PH1,
    ST_PH2,
    ST_FLUSH
  } state_e;

  function automatic logic [11:0] rgb565_to_444(input logic [15:0] d);
    return {d[15:12], d[10:7], d[4:1]};
  endfunction

endpackage

// File: rtl/pixel_unpacker.sv
// 16-bit word stream to RGB444 pixels (RGB565 or PACK12), with line header and pix_x.
// One-cycle output latency; axiir drops only for the PACK12 flush cycle.
module pixel_unpacker
  import pixel_unpack_pkg::*;
#(
  parameter int HEADER_EN = 1,
  parameter int LINE_Y_W  = 16,
  parameter int LINE_LEN  = 320,
  parameter int X_W       = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mode,
  input  logic                axiiv,
  input  logic [15:0]         axiid,
  output logic                axiir,
  output logic                axiov,
  output logic [11:0]         axiod,
  output logic [X_W-1:0]      pix_x,
  output logic [LINE_Y_W-1:0] line_y,
  output logic                line_y_valid,
  output logic                frag_err,
  output logic                ovf_err
);

  // One extra bit so the counter can saturate at LINE_LEN == 2**X_W.
  localparam int              CW         = X_W + 1;
  localparam logic [CW-1:0]   LINE_LEN_C = CW'(LINE_LEN);

  state_e                state_q, state_d;
  mode_e                 mode_q, mode_d;
  logic [11:0]           hold_q, hold_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  axiov_q, axiov_d;
  logic [11:0]           axiod_q, axiod_d;
  logic [X_W-1:0]        pix_x_q, pix_x_d;
  logic [LINE_Y_W-1:0]   line_y_q, line_y_d;
  logic                  lyv_q, lyv_d;
  logic                  frag_q, frag_d;
  logic                  ovf_q, ovf_d;

  logic                  take;
  logic                  emit;
  logic [11:0]           pix;
  logic [CW-1:0]         cnt_cur;
  state_e                phase;
  mode_e                 word_mode;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    hold_d    = hold_q;
    cnt_d     = cnt_q;
    axiov_d   = 1'b0;
    axiod_d   = axiod_q;
    pix_x_d   = pix_x_q;
    line_y_d  = line_y_q;
    lyv_d     = 1'b0;
    frag_d    = 1'b0;
    ovf_d     = 1'b0;
    take      = 1'b0;
    emit      = 1'b0;
    pix       = '0;
    cnt_cur   = cnt_q;
    phase     = state_q;
    word_mode = mode_q;

    case (state_q)
      ST_IDLE: begin
        if (axiiv) begin
          mode_d  = mode_e'(mode);
          cnt_cur = '0;
          cnt_d   = '0;
          if (HEADER_EN != 0) begin
            line_y_d = axiid[LINE_Y_W-1:0];
            lyv_d    = 1'b1;
            state_d  = ST_PH0;
          end else begin
            // Headerless burst: first word is data, decoded with the fresh mode.
            take      = 1'b1;
            phase     = ST_PH0;
            word_mode = mode_e'(mode);
          end
        end
      end
      ST_PH0, ST_PH1, ST_PH2: begin
        if (axiiv) begin
          take = 1'b1;
        end else begin
          state_d = ST_IDLE;
          frag_d  = (state_q != ST_PH0);
        end
      end
      ST_FLUSH: begin
        emit    = 1'b1;
        pix     = hold_q;
        state_d = ST_PH0;
      end
      default: state_d = ST_IDLE;
    endcase

    if (take) begin
      emit = 1'b1;
      case (phase)
        ST_PH1: begin
          pix     = {hold_q[3:0], axiid[15:8]};
          hold_d  = {4'h0, axiid[7:0]};
          state_d = ST_PH2;
        end
        ST_PH2: begin
          pix     = {hold_q[7:0], axiid[15:12]};
          hold_d  = axiid[11:0];
          state_d = ST_FLUSH;
        end
        default: begin
          if (word_mode == MODE_RGB565) begin
            pix     = rgb565_to_444(axiid);
            state_d = ST_PH0;
          end else begin
            pix     = axiid[15:4];
            hold_d  = {8'h00, axiid[3:0]};
            state_d = ST_PH1;
          end
        end
      endcase
    end

    if (emit) begin
      if (cnt_cur >= LINE_LEN_C) begin
        ovf_d = 1'b1;
        cnt_d = LINE_LEN_C;
      end else begin
        axiov_d = 1'b1;
        axiod_d = pix;
        pix_x_d = cnt_cur[X_W-1:0];
        cnt_d   = cnt_cur + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_RGB565;
      hold_q   <= '0;
      cnt_q    <= '0;
      axiov_q  <= 1'b0;
      axiod_q  <= '0;
      pix_x_q  <= '0;
      line_y_q <= '0;
      lyv_q    <= 1'b0;
      frag_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      hold_q   <= hold_d;
      cnt_q    <= cnt_d;
      axiov_q  <= axiov_d;
      axiod_q  <= axiod_d;
      pix_x_q  <= pix_x_d;
      line_y_q <= line_y_d;
      lyv_q    <= lyv_d;
      frag_q   <= frag_d;
      ovf_q    <= ovf_d;
    end
  end

  assign axiir        = (state_q != ST_FLUSH);
  assign axiov        = axiov_q;
  assign axiod        = axiod_q;
  assign pix_x        = pix_x_q;
  assign line_y       = line_y_q;
  assign line_y_valid = lyv_q;
  assign frag_err     = frag_q;
  assign ovf_err      = ovf_q;

endmodule

// File: tb/tb_pixel_unpacker.sv
// Self-checking bench for pixel_unpacker: three instances (header, headerless, short line)
// share one stimulus stream; the selected instance is observed into a scoreboard.
module tb_pixel_unpacker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        mode;
  logic        axiiv;
  logic [15:0] axiid;

  logic        rdy[3], vld[3], lyv[3], frag[3], ovf[3];
  logic [11:0] dat[3];
  logic [15:0] ly[3];
  logic [9:0]  x0, x1;
  logic [1:0]  x2;

  pixel_unpacker #(.HEADER_EN(1), .LINE_Y_W(16), .LINE_LEN(320), .X_W(10)) u_hdr (
    .clk(clk), .rst(rst), .mode(mode), .axiiv(axiiv), .axiid(axiid), .axiir(rdy[0]),
    .axiov(vld[0]), .axiod(dat[0]), .pix_x(x0), .line_y(ly[0]), .line_y_valid(lyv[0]),
    .frag_err(frag[0]), .ovf_err(ovf[0]));

  pixel_unpacker #(.HEADER_EN(0), .LINE_Y_W(16), .LINE_LEN(320), .X_W(10)) u_raw (
    .clk(clk), .rst(rst), .mode(mode), .axiiv(axiiv), .axiid(axiid), .axiir(rdy[1]),
    .axiov(vld[1]), .axiod(dat[1]), .pix_x(x1), .line_y(ly[1]), .line_y_valid(lyv[1]),
    .frag_err(frag[1]), .ovf_err(ovf[1]));

  pixel_unpacker #(.HEADER_EN(0), .LINE_Y_W(16), .LINE_LEN(4), .X_W(2)) u_ovf (
    .clk(clk), .rst(rst), .mode(mode), .axiiv(axiiv), .axiid(axiid), .axiir(rdy[2]),
    .axiov(vld[2]), .axiod(dat[2]), .pix_x(x2), .line_y(ly[2]), .line_y_valid(lyv[2]),
    .frag_err(frag[2]), .ovf_err(ovf[2]));

  int          sel;
  logic        m_vld, m_rdy, m_frag, m_ovf, m_lyv;
  logic [11:0] m_dat;
  logic [9:0]  m_x;
  logic [15:0] m_ly;

  always_comb begin
    m_vld = 1'b0; m_rdy = 1'b0; m_frag = 1'b0; m_ovf = 1'b0; m_lyv = 1'b0;
    m_dat = '0; m_x = '0; m_ly = '0;
    case (sel)
      0: begin m_vld = vld[0]; m_rdy = rdy[0]; m_frag = frag[0]; m_ovf = ovf[0];
               m_lyv = lyv[0]; m_dat = dat[0]; m_x = x0; m_ly = ly[0]; end
      1: begin m_vld = vld[1]; m_rdy = rdy[1]; m_frag = frag[1]; m_ovf = ovf[1];
               m_lyv = lyv[1]; m_dat = dat[1]; m_x = x1; m_ly = ly[1]; end
      default: begin m_vld = vld[2]; m_rdy = rdy[2]; m_frag = frag[2]; m_ovf = ovf[2];
               m_lyv = lyv[2]; m_dat = dat[2]; m_x = {8'h00, x2}; m_ly = ly[2]; end
    endcase
  end

  logic [21:0] exp_q[$];
  logic [21:0] obs_q[$];
  int frag_cnt, ovf_cnt, lyv_cnt, rdy_low_cnt;
  int checks = 0;
  int errors = 0;

  function automatic logic [11:0] m565(input logic [15:0] d);
    logic [4:0] r; logic [5:0] g; logic [4:0] b;
    r = d[15:11] >> 1; g = d[10:5] >> 2; b = d[4:0] >> 1;
    return {r[3:0], g[3:0], b[3:0]};
  endfunction

  function automatic logic [11:0] pk(input logic [47:0] grp, input int k);
    logic [47:0] t;
    t = grp << (12 * k);
    return t[47:36];
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (m_vld) obs_q.push_back({m_dat, m_x});
    if (m_frag) frag_cnt++;
    if (m_ovf) ovf_cnt++;
    if (m_lyv) lyv_cnt++;
    if (!m_rdy) rdy_low_cnt++;
  endtask

  task automatic send(input logic [15:0] w);
    bit done = 1'b0;
    axiiv = 1'b1;
    axiid = w;
    for (int i = 0; i < 8 && !done; i++) begin
      done = m_rdy;
      tick();
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_timeout: word %h not accepted within 8 cycles (required accept)", w);
    end
  endtask

  task automatic idle(input int n);
    axiiv = 1'b0;
    repeat (n) tick();
  endtask

  task automatic clear();
    exp_q.delete(); obs_q.delete();
    frag_cnt = 0; ovf_cnt = 0; lyv_cnt = 0; rdy_low_cnt = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b0; axiiv = 1'b0; axiid = '0; sel = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      checks += 8;
      if (m_vld !== 1'b0) begin errors++; $display("FAIL reset_axiov[%0d]: got %b want 0", s, m_vld); end
      if (m_dat !== 12'h0) begin errors++; $display("FAIL reset_axiod[%0d]: got %h want 0", s, m_dat); end
      if (m_x !== 10'd0) begin errors++; $display("FAIL reset_pix_x[%0d]: got %0d want 0", s, m_x); end
      if (m_ly !== 16'h0) begin errors++; $display("FAIL reset_line_y[%0d]: got %h want 0", s, m_ly); end
      if (m_lyv !== 1'b0) begin errors++; $display("FAIL reset_lyv[%0d]: got %b want 0", s, m_lyv); end
      if (m_frag !== 1'b0) begin errors++; $display("FAIL reset_frag[%0d]: got %b want 0", s, m_frag); end
      if (m_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf[%0d]: got %b want 0", s, m_ovf); end
      if (m_rdy !== 1'b1) begin errors++; $display("FAIL reset_axiir[%0d]: got %b want 1", s, m_rdy); end
    end
  endtask

  task automatic test_header();
    logic [21:0] e, o;
    sel = 0; clear(); mode = 1'b0;
    send(16'h0005);
    send(16'hFFFF); exp_q.push_back({12'hFFF, 10'd0});
    send(16'hF800); exp_q.push_back({12'hF00, 10'd1});
    idle(3);
    checks += 3;
    if (m_ly !== 16'd5) begin errors++; $display("FAIL hdr_line_y: got %h want 0005", m_ly); end
    if (lyv_cnt != 1) begin errors++; $display("FAIL hdr_lyv_pulses: got %0d want 1", lyv_cnt); end
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL hdr_count: got %0d pixels want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++;
        $display("FAIL hdr_pixel: got %h@%0d want %h@%0d", o[21:10], o[9:0], e[21:10], e[9:0]); end
    end
  endtask

  task automatic test_pack();
    logic [21:0] e, o;
    logic [47:0] g;
    logic        rdy_after_w2;
    sel = 1; clear(); mode = 1'b1;
    g = {16'h1234, 16'h5678, 16'h9ABC};
    for (int k = 0; k < 4; k++) exp_q.push_back({pk(g, k), 10'(k)});
    send(16'h1234); send(16'h5678); send(16'h9ABC);
    rdy_after_w2 = m_rdy;
    idle(3);
    checks += 3;
    if (rdy_after_w2 !== 1'b0) begin errors++; $display("FAIL pack_rdy_after_w2: got %b want 0", rdy_after_w2); end
    if (rdy_low_cnt != 1) begin errors++; $display("FAIL pack_rdy_low_cycles: got %0d want 1", rdy_low_cnt); end
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL pack_count: got %0d pixels want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++;
        $display("FAIL pack_pixel: got %h@%0d want %h@%0d", o[21:10], o[9:0], e[21:10], e[9:0]); end
    end
  endtask

  task automatic test_frag();
    logic [21:0] e, o;
    logic [47:0] g;
    sel = 1; clear(); mode = 1'b1;
    send(16'hABCD); exp_q.push_back({12'hABC, 10'd0});
    send(16'h1234); exp_q.push_back({12'hD12, 10'd1});
    idle(2);
    checks++;
    if (frag_cnt != 1) begin errors++; $display("FAIL frag_pulse: got %0d pulses want 1", frag_cnt); end
    g = {16'h1111, 16'h2222, 16'h3333};
    for (int k = 0; k < 4; k++) exp_q.push_back({pk(g, k), 10'(k)});
    send(16'h1111); send(16'h2222); send(16'h3333);
    idle(3);
    checks += 2;
    if (frag_cnt != 1) begin errors++; $display("FAIL frag_second_burst: got %0d pulses want 1", frag_cnt); end
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL frag_count: got %0d pixels want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++;
        $display("FAIL frag_pixel: got %h@%0d want %h@%0d", o[21:10], o[9:0], e[21:10], e[9:0]); end
    end
  endtask

  task automatic test_ovf();
    logic [21:0] e, o;
    logic [15:0] w;
    sel = 2; clear(); mode = 1'b0;
    for (int i = 0; i < 6; i++) begin
      w = 16'($urandom);
      if (i < 4) exp_q.push_back({m565(w), 10'(i)});
      send(w);
    end
    idle(3);
    checks += 2;
    if (ovf_cnt != 2) begin errors++; $display("FAIL ovf_pulses: got %0d want 2", ovf_cnt); end
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL ovf_count: got %0d pixels want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++;
        $display("FAIL ovf_pixel: got %h@%0d want %h@%0d", o[21:10], o[9:0], e[21:10], e[9:0]); end
    end
  endtask

  task automatic test_mode_toggle();
    logic [21:0] e, o;
    logic [15:0] w[3];
    logic [47:0] g;
    sel = 1; clear(); mode = 1'b0;
    w[0] = 16'hF81F; w[1] = 16'h07E0; w[2] = 16'h8421;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({m565(w[i]), 10'(i)});
      send(w[i]);
      mode = 1'b1;
    end
    idle(3);
    g = {16'hCAFE, 16'hBEEF, 16'h0F1E};
    for (int k = 0; k < 4; k++) exp_q.push_back({pk(g, k), 10'(k)});
    send(16'hCAFE); send(16'hBEEF); send(16'h0F1E);
    idle(3);
    checks += 2;
    if (frag_cnt != 0) begin errors++; $display("FAIL toggle_frag: got %0d pulses want 0", frag_cnt); end
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL toggle_count: got %0d pixels want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++;
        $display("FAIL toggle_pixel: got %h@%0d want %h@%0d", o[21:10], o[9:0], e[21:10], e[9:0]); end
    end
  endtask

  task automatic test_rst_mid();
    logic [21:0] e, o;
    logic [47:0] g;
    sel = 1; clear(); mode = 1'b1;
    g = {16'h4567, 16'h89AB, 16'hCDEF};
    exp_q.push_back({pk(g, 0), 10'd0});
    exp_q.push_back({pk(g, 1), 10'd1});
    send(16'h4567); send(16'h89AB);
    axiid = 16'hCDEF; axiiv = 1'b1; rst = 1'b1;
    tick();
    checks += 8;
    if (m_vld !== 1'b0) begin errors++; $display("FAIL rst_axiov: got %b want 0", m_vld); end
    if (m_dat !== 12'h0) begin errors++; $display("FAIL rst_axiod: got %h want 0", m_dat); end
    if (m_x !== 10'd0) begin errors++; $display("FAIL rst_pix_x: got %0d want 0", m_x); end
    if (m_frag !== 1'b0) begin errors++; $display("FAIL rst_frag: got %b want 0", m_frag); end
    if (m_ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b want 0", m_ovf); end
    if (m_rdy !== 1'b1) begin errors++; $display("FAIL rst_axiir: got %b want 1", m_rdy); end
    if (ly[0] !== 16'h0) begin errors++; $display("FAIL rst_line_y: got %h want 0", ly[0]); end
    if (lyv[0] !== 1'b0) begin errors++; $display("FAIL rst_lyv: got %b want 0", lyv[0]); end
    rst = 1'b0;
    idle(2);
    g = {16'h0123, 16'h4567, 16'h89AB};
    for (int k = 0; k < 4; k++) exp_q.push_back({pk(g, k), 10'(k)});
    send(16'h0123); send(16'h4567); send(16'h89AB);
    idle(3);
    checks += 2;
    if (frag_cnt != 0) begin errors++; $display("FAIL rst_frag_total: got %0d pulses want 0", frag_cnt); end
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rst_count: got %0d pixels want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++;
        $display("FAIL rst_pixel: got %h@%0d want %h@%0d", o[21:10], o[9:0], e[21:10], e[9:0]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [21:0] e, o;
    logic [15:0] w[6];
    logic [47:0] g;
    sel = 1; clear(); mode = 1'b1;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 6; i++) w[i] = 16'($urandom);
      for (int grp = 0; grp < 2; grp++) begin
        g = {w[3*grp], w[3*grp+1], w[3*grp+2]};
        for (int k = 0; k < 4; k++) exp_q.push_back({pk(g, k), 10'(4*grp + k)});
      end
      for (int i = 0; i < 6; i++) send(w[i]);
      idle(2);
    end
    idle(2);
    checks += 2;
    if (frag_cnt != 0) begin errors++; $display("FAIL b2b_frag: got %0d pulses want 0", frag_cnt); end
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL b2b_count: got %0d pixels want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++;
        $display("FAIL b2b_pixel: got %h@%0d want %h@%0d", o[21:10], o[9:0], e[21:10], e[9:0]); end
    end
  endtask

  initial begin
    test_reset();
    test_header();
    test_pack();
    test_frag();
    test_ovf();
    test_mode_toggle();
    test_rst_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 time units (required finish)");
    $fatal(1);
  end

endmodule
